// File: rtl/fsm_serial_word_tx_if.sv
// rtl/fsm_serial_word_tx_if.sv - load handshake and serial framing bundle for the word transmitter
interface fsm_serial_word_tx_if #(
    parameter int WIDTH = 5
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             data_out;
    logic             bit_valid;
    logic             frame_start;
    logic             frame_end;
    logic             prefix_div3;
    logic             frame_div3;
    logic             busy;

    // master is the word source / stream observer, slave is the transmitter
    modport master (
        output load_valid, load_data,
        input  load_ready, data_out, bit_valid, frame_start, frame_end,
               prefix_div3, frame_div3, busy
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, data_out, bit_valid, frame_start, frame_end,
               prefix_div3, frame_div3, busy
    );
endinterface

// File: rtl/fsm_serial_word_tx.sv
// rtl/fsm_serial_word_tx.sv - MSB-first serial word transmitter with running mod-3 divisibility flag
module fsm_serial_word_tx #(
    parameter int WIDTH = 5,
    parameter int GAP   = 0
) (
    input  logic                clk,
    input  logic                reset,
    fsm_serial_word_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0]    S_IDLE   = 2'd0;
    localparam logic [1:0]    S_SHIFT  = 2'd1;
    localparam logic [1:0]    S_GAP    = 2'd2;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       res_q, res_d;
    logic [3:0]       gap_q, gap_d;
    logic             fdiv_q, fdiv_d;

    logic       shifting;
    logic       cur_bit;
    logic       frame_end;
    logic       prefix;
    logic       handshake;
    logic [1:0] res_next;

    assign shifting  = (state_q == S_SHIFT);
    assign cur_bit   = shreg_q[WIDTH-1];
    assign frame_end = shifting & (cnt_q == '0);

    // residue of (2*r + bit) mod 3, kept within 0..2
    always_comb begin
        res_next = 2'd0;
        case (res_q)
            2'd0:    res_next = cur_bit ? 2'd1 : 2'd0;
            2'd1:    res_next = cur_bit ? 2'd0 : 2'd2;
            2'd2:    res_next = cur_bit ? 2'd2 : 2'd1;
            default: res_next = 2'd0;
        endcase
    end

    assign prefix = shifting & (res_next == 2'd0);

    // with no gap the next word may be accepted during the last bit
    assign bus.load_ready  = reset & ((state_q == S_IDLE) | ((GAP == 0) & frame_end));
    assign handshake       = bus.load_valid & bus.load_ready;

    assign bus.data_out    = shifting & cur_bit;
    assign bus.bit_valid   = shifting;
    assign bus.frame_start = shifting & (cnt_q == CNT_LAST);
    assign bus.frame_end   = frame_end;
    assign bus.prefix_div3 = prefix;
    assign bus.frame_div3  = fdiv_q;
    assign bus.busy        = (state_q == S_SHIFT) | (state_q == S_GAP);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        gap_d   = gap_q;
        fdiv_d  = fdiv_q;
        case (state_q)
            S_IDLE: ;
            S_SHIFT: begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - CW'(1);
                res_d   = res_next;
                if (frame_end) begin
                    fdiv_d  = prefix;
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
                    gap_d   = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (handshake) begin
            shreg_d = bus.load_data;
            cnt_d   = CNT_LAST;
            res_d   = 2'd0;
            state_d = S_SHIFT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            res_q   <= 2'd0;
            gap_q   <= 4'd0;
            fdiv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            gap_q   <= gap_d;
            fdiv_q  <= fdiv_d;
        end
    end
endmodule

// File: tb/tb_fsm_serial_word_tx.sv
// tb/tb_fsm_serial_word_tx.sv - bench for fsm_serial_word_tx with GAP=0 and GAP=3 instances
module tb_fsm_serial_word_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic [4:0] load_data = 5'd0;
    logic       chk_en = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    fsm_serial_word_tx_if #(.WIDTH(5)) bus0 ();
    fsm_serial_word_tx_if #(.WIDTH(5)) bus3 ();

    assign bus0.load_valid = load_valid;
    assign bus0.load_data  = load_data;
    assign bus3.load_valid = load_valid;
    assign bus3.load_data  = load_data;

    fsm_serial_word_tx #(.WIDTH(5), .GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    fsm_serial_word_tx #(.WIDTH(5), .GAP(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    // {load_ready, data_out, bit_valid, frame_start, frame_end, prefix_div3, frame_div3, busy}
    logic [7:0] act [2];
    assign act[0] = {bus0.load_ready, bus0.data_out, bus0.bit_valid, bus0.frame_start,
                     bus0.frame_end, bus0.prefix_div3, bus0.frame_div3, bus0.busy};
    assign act[1] = {bus3.load_ready, bus3.data_out, bus3.bit_valid, bus3.frame_start,
                     bus3.frame_end, bus3.prefix_div3, bus3.frame_div3, bus3.busy};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: position of the bit on the line within the word, gap cycles left
    int         m_pos  [2] = '{-1, -1};
    int         m_gap  [2] = '{0, 0};
    logic [4:0] m_word [2] = '{5'd0, 5'd0};
    logic       m_fdiv [2] = '{1'b0, 1'b0};

    function automatic int gap_of(int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic logic model_ready(int i);
        return reset && ((m_pos[i] < 0 && m_gap[i] == 0) || (gap_of(i) == 0 && m_pos[i] == 4));
    endfunction

    function automatic logic [7:0] model_out(int i);
        logic       sh;
        logic [4:0] pfx;
        sh  = (m_pos[i] >= 0);
        pfx = sh ? (m_word[i] >> (4 - m_pos[i])) : 5'd0;
        return {model_ready(i), sh & pfx[0], sh, sh && m_pos[i] == 0, sh && m_pos[i] == 4,
                sh && ((pfx % 3) == 0), m_fdiv[i], sh || m_gap[i] > 0};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_pos[i]  <= -1;
                m_gap[i]  <= 0;
                m_word[i] <= 5'd0;
                m_fdiv[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_pos[i] == 4) m_fdiv[i] <= ((m_word[i] % 3) == 0);
                if (m_pos[i] >= 0) begin
                    if (m_pos[i] == 4) begin
                        m_pos[i] <= -1;
                        m_gap[i] <= gap_of(i);
                    end else begin
                        m_pos[i] <= m_pos[i] + 1;
                    end
                end else if (m_gap[i] > 0) begin
                    m_gap[i] <= m_gap[i] - 1;
                end
                if (load_valid && model_ready(i)) begin
                    m_word[i] <= load_data;
                    m_pos[i]  <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++)
                check($sformatf("model_dut%0d", i), 32'(act[i]), 32'(model_out(i)));
        end
    end

    typedef struct {
        logic [4:0] word;
        logic [4:0] bits;
        logic [4:0] pref;
        logic       fdiv;
    } vec_t;
    vec_t vec [5];

    task automatic wait_idle();
        int n = 0;
        while (!(act[0][7] && !act[0][0] && act[1][7] && !act[1][0]) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle_timeout", 32'(n < 60), 32'(1));
    endtask

    task automatic run_row(input int r);
        wait_idle();
        load_valid = 1'b1;
        load_data  = vec[r].word;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("row%0d_bit%0d_data", r, k), 32'(bus0.data_out), 32'(vec[r].bits[4-k]));
            check($sformatf("row%0d_bit%0d_pfx", r, k), 32'(bus0.prefix_div3), 32'(vec[r].pref[4-k]));
            check($sformatf("row%0d_bit%0d_fs", r, k), 32'(bus0.frame_start), 32'(k == 0));
            check($sformatf("row%0d_bit%0d_fe", r, k), 32'(bus0.frame_end), 32'(k == 4));
        end
        @(posedge clk);
        #1;
        check($sformatf("row%0d_frame_div3", r), 32'(bus0.frame_div3), 32'(vec[r].fdiv));
    endtask

    initial begin
        logic [9:0] got;
        int         nbv;
        logic [9:0] b2b_exp;

        vec[0] = '{5'd21, 5'b10101, 5'b00001, 1'b1};
        vec[1] = '{5'd22, 5'b10110, 5'b00000, 1'b0};
        vec[2] = '{5'd0,  5'b00000, 5'b11111, 1'b1};
        vec[3] = '{5'd31, 5'b11111, 5'b01010, 1'b0};
        vec[4] = '{5'd6,  5'b00110, 5'b11011, 1'b1};
        b2b_exp = {5'd21, 5'd22};

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        check("reset_outputs_dut0", 32'(act[0]), 32'(0));
        check("reset_outputs_dut3", 32'(act[1]), 32'(0));
        reset = 1'b1;
        #1;
        check("ready_after_release", 32'(bus0.load_ready), 32'(1));
        @(posedge clk);
        #1;

        for (int r = 0; r < 5; r++) run_row(r);

        // back-to-back on GAP=0, with junk on load_data while busy
        wait_idle();
        load_valid = 1'b1;
        load_data  = 5'd21;
        @(posedge clk);
        #1;
        nbv = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 4) load_data = 5'($urandom);
            if (k == 4) load_data = 5'd22;
            if (k == 5) load_valid = 1'b0;
            @(negedge clk);
            nbv += int'(bus0.bit_valid);
            got[9-k] = bus0.data_out;
            if (k == 4) begin
                check("b2b_ready_in_end", 32'(bus0.load_ready), 32'(1));
                check("b2b_end_strobe", 32'(bus0.frame_end), 32'(1));
            end
            @(posedge clk);
            #1;
        end
        check("b2b_bit_valid_count", 32'(nbv), 32'(10));
        check("b2b_bits", 32'(got), 32'(b2b_exp));

        // GAP=3: frame, three gap cycles, one idle handshake cycle, next frame
        wait_idle();
        load_valid = 1'b1;
        load_data  = 5'd21;
        @(posedge clk);
        #1;
        load_data = 5'd22;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("gap3_c%0d_bv", k), 32'(bus3.bit_valid), 32'(k < 5 || k == 9));
            check($sformatf("gap3_c%0d_ready", k), 32'(bus3.load_ready), 32'(k == 8));
            check($sformatf("gap3_c%0d_busy", k), 32'(bus3.busy), 32'(k != 8));
            check($sformatf("gap3_c%0d_fs", k), 32'(bus3.frame_start), 32'(k == 0 || k == 9));
            @(posedge clk);
            #1;
            if (k == 8) load_valid = 1'b0;
        end

        // reset during the third bit of a frame
        wait_idle();
        load_valid = 1'b1;
        load_data  = 5'd21;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midreset_dut0", 32'(act[0]), 32'(0));
        check("midreset_dut3", 32'(act[1]), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_fdiv", 32'(bus0.frame_div3), 32'(0));
        run_row(0);

        // randomized traffic with occasional reset pulses
        for (int n = 0; n < 400; n++) begin
            load_valid = ($urandom_range(0, 2) != 0);
            load_data  = 5'($urandom);
            reset      = ($urandom_range(0, 40) != 0);
            @(posedge clk);
            #1;
        end
        reset      = 1'b1;
        load_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
